// File: rtl/spi_adc_pkg.sv
// Shared types and constants for the SPI ADC responder.
// The frame is a short command header followed by one sample.
package spi_adc_pkg;

    localparam int CMD_BITS_DEF = 4;
    localparam int DATA_W_DEF   = 12;
    localparam int FRAME_BITS   = CMD_BITS_DEF + DATA_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin.
// Provides the synchronized level and single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {(STAGES + 1){RST_VAL}};
        end else begin
            chain <= {chain[STAGES-1:0], din};
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = chain[STAGES-1] & ~chain[STAGES];
    assign fall  = ~chain[STAGES-1] & chain[STAGES];

endmodule

// File: rtl/spi_adc_responder.sv
// SPI mode-0 slave emulating a two-channel ADC: 4-bit command in,
// selected sample out on MISO, MSB first.
module spi_adc_responder
    import spi_adc_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CMD_BITS    = CMD_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              mosi,
    input  logic [DATA_W-1:0] sample_ch0,
    input  logic [DATA_W-1:0] sample_ch1,
    output logic              miso,
    output logic              miso_oe,
    output logic              channel,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int FRAME_LEN = CMD_BITS + DATA_W;
    localparam int CW        = $clog2(FRAME_LEN + 1);
    localparam int IW        = $clog2(DATA_W);
    localparam int WW        = $clog2(SYNC_STAGES + 2);

    state_t state;
    state_t state_nx;

    logic sck_lvl_unused;
    logic sck_rise;
    logic sck_fall;
    logic cs_lvl;
    logic cs_rise;
    logic cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic mosi_s;

    logic [WW-1:0] warm;
    logic armed;
    logic start;

    logic [CW-1:0] bit_cnt;
    logic start_ok;
    logic sel;
    logic [DATA_W-1:0] shadow0;
    logic [DATA_W-1:0] shadow1;
    logic [DATA_W-1:0] cur_word;
    logic [IW-1:0] idx;

    logic miso_nx;
    logic done_nx;
    logic err_nx;

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sck),
        .level (sck_lvl_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cs_n),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // A CS that was already low when reset released must not start a
    // frame: wait for the chain to refill and see CS high first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm  <= '0;
            armed <= 1'b0;
        end else begin
            if (warm != WW'(SYNC_STAGES)) begin
                warm <= warm + 1'b1;
            end
            if (warm == WW'(SYNC_STAGES) && cs_lvl) begin
                armed <= 1'b1;
            end
        end
    end

    assign start    = cs_fall & armed & (state == IDLE);
    assign cur_word = sel ? shadow1 : shadow0;
    assign idx      = IW'(CW'(FRAME_LEN - 1) - bit_cnt);
    assign miso_oe  = ~cs_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = CMD;
            end
            CMD: begin
                if (cs_rise) begin
                    state_nx = IDLE;
                end else if (sck_rise && bit_cnt == CW'(CMD_BITS - 1)) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (cs_rise) begin
                    state_nx = IDLE;
                end else if (sck_rise && bit_cnt == CW'(FRAME_LEN - 1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (cs_rise) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        done_nx = cs_rise & (state == DONE) & start_ok;
        err_nx  = cs_rise & (((state == DONE) & ~start_ok) |
                             (state == CMD) | (state == DATA));
        miso_nx = miso;
        if (state_nx != DATA) begin
            miso_nx = 1'b0;
        end else if (sck_fall) begin
            miso_nx = start_ok & cur_word[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            start_ok   <= 1'b0;
            sel        <= 1'b0;
            shadow0    <= '0;
            shadow1    <= '0;
            miso       <= 1'b0;
            channel    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if ((state == CMD || state == DATA) && sck_rise) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (start) begin
                shadow0  <= sample_ch0;
                shadow1  <= sample_ch1;
                start_ok <= 1'b0;
                sel      <= 1'b0;
            end
            if (state == CMD && sck_rise && bit_cnt == CW'(0)) begin
                start_ok <= mosi_s;
            end
            if (state == CMD && sck_rise && bit_cnt == CW'(1)) begin
                sel <= mosi_s;
            end
            if (done_nx) begin
                channel <= sel;
            end
            miso       <= miso_nx;
            frame_done <= done_nx;
            frame_err  <= err_nx;
        end
    end

endmodule
